// File: rtl/gif_sram_arbiter.sv
// Purpose: frame-buffer SRAM controller arbitrating a CPU Avalon-MM slave against a read-only video scanout port.
// Latency: request granted in IDLE, WAIT_CYC+1 ACCESS cycles, DONE at grant+WAIT_CYC+2; writes then idle TURN_CYC cycles.
// Backpressure: CPU held by avs_waitrequest (low one cycle per completed access); video holds vid_req until vid_ack.
//
// Ports:
//   clk_clk, reset_reset        : clock, synchronous active-high reset
//   avs_*                       : CPU Avalon-MM slave (address, read, write, writedata, byteenable,
//                                 readdata, waitrequest)
//   vid_req/vid_addr/vid_ack    : video request handshake; vid_data/vid_valid return the word
//   sram_wire_*                 : asynchronous SRAM pins (DQ bidirectional, strobes active-low)
module gif_sram_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 20,
    parameter int WAIT_CYC   = 1,
    parameter int TURN_CYC   = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,

    input  logic [ADDR_W-1:0]      avs_address,
    input  logic                   avs_read,
    input  logic                   avs_write,
    input  logic [DATA_W-1:0]      avs_writedata,
    input  logic [DATA_W/8-1:0]    avs_byteenable,
    output logic [DATA_W-1:0]      avs_readdata,
    output logic                   avs_waitrequest,

    input  logic                   vid_req,
    input  logic [ADDR_W-1:0]      vid_addr,
    output logic                   vid_ack,
    output logic [DATA_W-1:0]      vid_data,
    output logic                   vid_valid,

    inout  wire  [DATA_W-1:0]      sram_wire_DQ,
    output logic [ADDR_W-1:0]      sram_wire_ADDR,
    output logic [DATA_W/8-1:0]    sram_wire_BE_N,
    output logic                   sram_wire_CE_N,
    output logic                   sram_wire_OE_N,
    output logic                   sram_wire_WE_N
);

    localparam int NB = DATA_W / 8;

    localparam logic [2:0] WAIT_LOAD  = 3'(WAIT_CYC);
    // TURN counts down to zero, so the load value is one less than the cycle count.
    localparam logic [2:0] TURN_LOAD  = (TURN_CYC > 0) ? 3'(TURN_CYC - 1) : 3'd0;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_TURN
    } state_t;

    state_t              state_q,    state_d;
    logic [2:0]          cnt_q,      cnt_d;
    logic [7:0]          streak_q,   streak_d;
    logic                is_wr_q,    is_wr_d;
    logic                is_vid_q,   is_vid_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdat_q,     wdat_d;
    logic [NB-1:0]       ben_q,      ben_d;
    logic [DATA_W-1:0]   cpu_rdat_q, cpu_rdat_d;
    logic [DATA_W-1:0]   vid_rdat_q, vid_rdat_d;

    // Arbitration: video normally wins; once the CPU has watched STARVE_MAX
    // video grants go by, it takes the next slot.
    logic cpu_req;
    logic cpu_wins;
    logic vid_wins;
    logic grant_cpu;
    logic grant_vid;
    logic dq_oe;

    assign cpu_req   = avs_read | avs_write;
    assign cpu_wins  = cpu_req && (!vid_req || (streak_q == STARVE_LIM));
    assign vid_wins  = vid_req && !cpu_wins;
    assign grant_cpu = (state_q == S_IDLE) && cpu_wins;
    assign grant_vid = (state_q == S_IDLE) && vid_wins;

    //------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        is_wr_d    = is_wr_q;
        is_vid_d   = is_vid_q;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        ben_d      = ben_q;
        cpu_rdat_d = cpu_rdat_q;
        vid_rdat_d = vid_rdat_q;

        case (state_q)
            S_IDLE: begin
                if (grant_vid) begin
                    state_d  = S_ACCESS;
                    cnt_d    = WAIT_LOAD;
                    is_wr_d  = 1'b0;
                    is_vid_d = 1'b1;
                    addr_d   = vid_addr;
                    // Scanout always fetches whole words.
                    ben_d    = '0;
                    if (cpu_req) begin
                        streak_d = streak_q + 8'd1;
                    end
                end else if (grant_cpu) begin
                    state_d  = S_ACCESS;
                    cnt_d    = WAIT_LOAD;
                    // Read and write together resolve to a write.
                    is_wr_d  = avs_write;
                    is_vid_d = 1'b0;
                    addr_d   = avs_address;
                    wdat_d   = avs_writedata;
                    ben_d    = ~avs_byteenable;
                    streak_d = 8'd0;
                end
            end

            S_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_DONE;
                    // Sample the bus on the last access cycle, while OE_N is still low.
                    if (!is_wr_q) begin
                        if (is_vid_q) begin
                            vid_rdat_d = sram_wire_DQ;
                        end else begin
                            cpu_rdat_d = sram_wire_DQ;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            S_DONE: begin
                if (is_wr_q && (TURN_CYC > 0)) begin
                    state_d = S_TURN;
                    cnt_d   = TURN_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_TURN: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // State registers
    //------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            streak_q   <= 8'd0;
            is_wr_q    <= 1'b0;
            is_vid_q   <= 1'b0;
            addr_q     <= '0;
            ben_q      <= '1;
            cpu_rdat_q <= '0;
            vid_rdat_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            is_wr_q    <= is_wr_d;
            is_vid_q   <= is_vid_d;
            addr_q     <= addr_d;
            ben_q      <= ben_d;
            cpu_rdat_q <= cpu_rdat_d;
            vid_rdat_q <= vid_rdat_d;
        end
    end

    // Write data is only ever put on the bus under control of the state
    // machine, so it needs no reset value.
    always_ff @(posedge clk_clk) begin
        wdat_q <= wdat_d;
    end

    //------------------------------------------------------------------
    // Pin and port decode (from registered state only, except vid_ack)
    //------------------------------------------------------------------
    always_comb begin
        sram_wire_CE_N  = 1'b1;
        sram_wire_OE_N  = 1'b1;
        sram_wire_WE_N  = 1'b1;
        sram_wire_BE_N  = '1;
        dq_oe           = 1'b0;
        avs_waitrequest = 1'b1;
        vid_valid       = 1'b0;

        case (state_q)
            S_ACCESS: begin
                sram_wire_CE_N = 1'b0;
                sram_wire_BE_N = ben_q;
                if (is_wr_q) begin
                    sram_wire_WE_N = 1'b0;
                    dq_oe          = 1'b1;
                end else begin
                    sram_wire_OE_N = 1'b0;
                end
            end

            S_DONE: begin
                // Strobes are released; address and data stay put for hold time.
                dq_oe = is_wr_q;
                if (is_vid_q) begin
                    vid_valid = 1'b1;
                end else begin
                    avs_waitrequest = 1'b0;
                end
            end

            default: begin
            end
        endcase
    end

    // A grant made while reset is high is discarded, so it must not be acknowledged.
    assign vid_ack        = grant_vid && !reset_reset;
    assign sram_wire_ADDR = addr_q;
    assign sram_wire_DQ   = dq_oe ? wdat_q : {DATA_W{1'bz}};
    assign avs_readdata   = cpu_rdat_q;
    assign vid_data       = vid_rdat_q;

endmodule

// File: tb/tb_gif_sram_arbiter.sv
// Purpose: self-checking bench for gif_sram_arbiter (default 16-bit build plus a 32-bit zero-wait build).
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_gif_sram_arbiter;

    logic clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    logic reset_reset;

    // Default build: DATA_W=16, WAIT_CYC=1, TURN_CYC=1, STARVE_MAX=8
    logic [19:0] avs_address;
    logic        avs_read, avs_write;
    logic [15:0] avs_writedata;
    logic [1:0]  avs_byteenable;
    logic [15:0] avs_readdata;
    logic        avs_waitrequest;
    logic        vid_req;
    logic [19:0] vid_addr;
    logic        vid_ack;
    logic [15:0] vid_data;
    logic        vid_valid;
    wire  [15:0] dq;
    logic [19:0] sram_addr;
    logic [1:0]  be_n;
    logic        ce_n, oe_n, we_n;

    // 32-bit build: WAIT_CYC=0, TURN_CYC=0
    logic [19:0] avs_address_w;
    logic        avs_read_w, avs_write_w;
    logic [31:0] avs_writedata_w;
    logic [3:0]  avs_byteenable_w;
    logic [31:0] avs_readdata_w;
    logic        avs_waitrequest_w;
    logic        vid_ack_w;
    logic [31:0] vid_data_w;
    logic        vid_valid_w;
    wire  [31:0] dq_w;
    logic [19:0] sram_addr_w;
    logic [3:0]  be_n_w;
    logic        ce_n_w, oe_n_w, we_n_w;

    gif_sram_arbiter u_dut (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_byteenable  (avs_byteenable),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .vid_req         (vid_req),
        .vid_addr        (vid_addr),
        .vid_ack         (vid_ack),
        .vid_data        (vid_data),
        .vid_valid       (vid_valid),
        .sram_wire_DQ    (dq),
        .sram_wire_ADDR  (sram_addr),
        .sram_wire_BE_N  (be_n),
        .sram_wire_CE_N  (ce_n),
        .sram_wire_OE_N  (oe_n),
        .sram_wire_WE_N  (we_n)
    );

    gif_sram_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (20),
        .WAIT_CYC   (0),
        .TURN_CYC   (0),
        .STARVE_MAX (8)
    ) u_dut32 (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .avs_address     (avs_address_w),
        .avs_read        (avs_read_w),
        .avs_write       (avs_write_w),
        .avs_writedata   (avs_writedata_w),
        .avs_byteenable  (avs_byteenable_w),
        .avs_readdata    (avs_readdata_w),
        .avs_waitrequest (avs_waitrequest_w),
        .vid_req         (1'b0),
        .vid_addr        (20'h0),
        .vid_ack         (vid_ack_w),
        .vid_data        (vid_data_w),
        .vid_valid       (vid_valid_w),
        .sram_wire_DQ    (dq_w),
        .sram_wire_ADDR  (sram_addr_w),
        .sram_wire_BE_N  (be_n_w),
        .sram_wire_CE_N  (ce_n_w),
        .sram_wire_OE_N  (oe_n_w),
        .sram_wire_WE_N  (we_n_w)
    );

    // SRAM models: drive DQ while CE_N and OE_N are low, write enabled lanes while WE_N is low.
    logic [15:0] mem16 [256];
    logic [31:0] mem32 [256];
    logic        probe_en;

    assign dq   = (!ce_n && !oe_n) ? mem16[sram_addr[7:0]] : 16'hzzzz;
    // Weak-looking probe: when enabled, a floating bus reads as zero; any DUT drive shows up.
    assign dq   = probe_en ? 16'h0000 : 16'hzzzz;
    assign dq_w = (!ce_n_w && !oe_n_w) ? mem32[sram_addr_w[7:0]] : 32'hzzzz_zzzz;

    always @(posedge clk_clk) begin
        if (!ce_n && !we_n) begin
            for (int b = 0; b < 2; b++) begin
                if (!be_n[b]) mem16[sram_addr[7:0]][8*b +: 8] = dq[8*b +: 8];
            end
        end
        if (!ce_n_w && !we_n_w) begin
            for (int b = 0; b < 4; b++) begin
                if (!be_n_w[b]) mem32[sram_addr_w[7:0]][8*b +: 8] = dq_w[8*b +: 8];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_clk);
        #1;
    endtask

    // Control vector layout: {waitrequest, CE_N, OE_N, WE_N, BE_N[1:0], vid_ack, vid_valid}
    localparam logic [7:0] C_IDLE      = 8'b1_1_1_1_11_0_0;
    localparam logic [7:0] C_IDLE_VACK = 8'b1_1_1_1_11_1_0;
    localparam logic [7:0] C_ACC_RD    = 8'b1_0_0_1_00_0_0;
    localparam logic [7:0] C_ACC_RD_LO = 8'b1_0_0_1_10_0_0;
    localparam logic [7:0] C_ACC_WR    = 8'b1_0_1_0_01_0_0;
    localparam logic [7:0] C_DONE_CPU  = 8'b0_1_1_1_11_0_0;
    localparam logic [7:0] C_DONE_VID  = 8'b1_1_1_1_11_0_1;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_DAT  = 2'd1;
    localparam logic [1:0] K_DQ   = 2'd2;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [19:0] addr;
        logic [15:0] wdat;
        logic [1:0]  be;
        logic        vreq;
        logic [19:0] vaddr;
        logic [7:0]  ctl;
        logic [1:0]  kind;
        logic [15:0] ev;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [19:0] a,
                                input logic [15:0] wd, input logic [1:0] be, input logic vr,
                                input logic [19:0] va, input logic [7:0] ctl,
                                input logic [1:0] kind, input logic [15:0] ev);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdat = wd; v.be = be;
        v.vreq = vr; v.vaddr = va; v.ctl = ctl; v.kind = kind; v.ev = ev;
        return v;
    endfunction

    localparam int NV = 24;
    vec_t vt [NV];

    logic [7:0] got_ctl;
    int acks, comps, vals, wcnt, dcnt;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // CPU read of 0x00123 (model holds 0xBEEF)
        vt[0]  = mk(1'b1, 1'b0, 20'h00123, 16'h0000, 2'b11, 1'b0, 20'h0, C_IDLE,      K_NONE, 16'h0);
        vt[1]  = mk(1'b1, 1'b0, 20'h00123, 16'h0000, 2'b11, 1'b0, 20'h0, C_ACC_RD,    K_NONE, 16'h0);
        vt[2]  = mk(1'b1, 1'b0, 20'h00123, 16'h0000, 2'b11, 1'b0, 20'h0, C_ACC_RD,    K_NONE, 16'h0);
        vt[3]  = mk(1'b1, 1'b0, 20'h00123, 16'h0000, 2'b11, 1'b0, 20'h0, C_DONE_CPU,  K_DAT,  16'hBEEF);
        vt[4]  = mk(1'b0, 1'b0, 20'h00000, 16'h0000, 2'b11, 1'b0, 20'h0, C_IDLE,      K_NONE, 16'h0);
        // CPU write 0xA55A to 0x00010, upper lane only, then TURN
        vt[5]  = mk(1'b0, 1'b1, 20'h00010, 16'hA55A, 2'b10, 1'b0, 20'h0, C_IDLE,      K_NONE, 16'h0);
        vt[6]  = mk(1'b0, 1'b1, 20'h00010, 16'hA55A, 2'b10, 1'b0, 20'h0, C_ACC_WR,    K_DQ,   16'hA55A);
        vt[7]  = mk(1'b0, 1'b1, 20'h00010, 16'hA55A, 2'b10, 1'b0, 20'h0, C_ACC_WR,    K_NONE, 16'h0);
        vt[8]  = mk(1'b0, 1'b1, 20'h00010, 16'hA55A, 2'b10, 1'b0, 20'h0, C_DONE_CPU,  K_DQ,   16'hA55A);
        // Read presented during TURN waits one cycle; read-back shows lower lane untouched
        vt[9]  = mk(1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11, 1'b0, 20'h0, C_IDLE,      K_NONE, 16'h0);
        vt[10] = mk(1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11, 1'b0, 20'h0, C_IDLE,      K_NONE, 16'h0);
        vt[11] = mk(1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11, 1'b0, 20'h0, C_ACC_RD,    K_NONE, 16'h0);
        vt[12] = mk(1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11, 1'b0, 20'h0, C_ACC_RD,    K_NONE, 16'h0);
        vt[13] = mk(1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11, 1'b0, 20'h0, C_DONE_CPU,  K_DAT,  16'hA534);
        vt[14] = mk(1'b0, 1'b0, 20'h00000, 16'h0000, 2'b11, 1'b0, 20'h0, C_IDLE,      K_NONE, 16'h0);
        // Simultaneous first requests: video first (valid at +3), CPU done at +7
        vt[15] = mk(1'b1, 1'b0, 20'h00055, 16'h0000, 2'b01, 1'b1, 20'h10, C_IDLE_VACK, K_NONE, 16'h0);
        vt[16] = mk(1'b1, 1'b0, 20'h00055, 16'h0000, 2'b01, 1'b0, 20'h0, C_ACC_RD,    K_NONE, 16'h0);
        vt[17] = mk(1'b1, 1'b0, 20'h00055, 16'h0000, 2'b01, 1'b0, 20'h0, C_ACC_RD,    K_NONE, 16'h0);
        vt[18] = mk(1'b1, 1'b0, 20'h00055, 16'h0000, 2'b01, 1'b0, 20'h0, C_DONE_VID,  K_DAT,  16'hA534);
        vt[19] = mk(1'b1, 1'b0, 20'h00055, 16'h0000, 2'b01, 1'b0, 20'h0, C_IDLE,      K_NONE, 16'h0);
        vt[20] = mk(1'b1, 1'b0, 20'h00055, 16'h0000, 2'b01, 1'b0, 20'h0, C_ACC_RD_LO, K_NONE, 16'h0);
        vt[21] = mk(1'b1, 1'b0, 20'h00055, 16'h0000, 2'b01, 1'b0, 20'h0, C_ACC_RD_LO, K_NONE, 16'h0);
        vt[22] = mk(1'b1, 1'b0, 20'h00055, 16'h0000, 2'b01, 1'b0, 20'h0, C_DONE_CPU,  K_DAT,  16'h6C3A);
        vt[23] = mk(1'b0, 1'b0, 20'h00000, 16'h0000, 2'b11, 1'b0, 20'h0, C_IDLE,      K_NONE, 16'h0);

        for (int i = 0; i < 256; i++) begin
            mem16[i] = 16'h0000;
            mem32[i] = 32'h0;
        end
        mem16[8'h23] = 16'hBEEF;
        mem16[8'h10] = 16'h1234;
        mem16[8'h55] = 16'h6C3A;
        mem32[8'h05] = 32'hDEADBEEF;
        mem32[8'h06] = 32'hFFFFFFFF;

        reset_reset = 1'b1;
        probe_en = 1'b0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0; avs_byteenable = '0;
        vid_req = 1'b0; vid_addr = '0;
        avs_address_w = '0; avs_read_w = 1'b0; avs_write_w = 1'b0; avs_writedata_w = '0;
        avs_byteenable_w = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk_clk);
        #1 probe_en = 1'b1;
        @(negedge clk_clk);
        got_ctl = {avs_waitrequest, ce_n, oe_n, we_n, be_n, vid_ack, vid_valid};
        chk("reset_ctl",   32'(got_ctl), 32'(C_IDLE));
        chk("reset_addr",  32'(sram_addr), 32'h0);
        chk("reset_rdata", 32'(avs_readdata), 32'h0);
        chk("reset_vdata", 32'(vid_data), 32'h0);
        chk("reset_dq",    32'(dq), 32'h0);
        chk("reset32_ctl", 32'({avs_waitrequest_w, ce_n_w, oe_n_w, we_n_w, be_n_w}), 32'hFF);
        tick;
        reset_reset = 1'b0;
        probe_en = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            avs_read = vt[i].rd;   avs_write = vt[i].wr;   avs_address = vt[i].addr;
            avs_writedata = vt[i].wdat; avs_byteenable = vt[i].be;
            vid_req = vt[i].vreq;  vid_addr = vt[i].vaddr;
            @(negedge clk_clk);
            got_ctl = {avs_waitrequest, ce_n, oe_n, we_n, be_n, vid_ack, vid_valid};
            chk($sformatf("vec%0d_ctl", i), 32'(got_ctl), 32'(vt[i].ctl));
            if (vt[i].kind == K_DAT)
                chk($sformatf("vec%0d_data", i), vt[i].ctl[0] ? 32'(vid_data) : 32'(avs_readdata),
                    32'(vt[i].ev));
            if (vt[i].kind == K_DQ)
                chk($sformatf("vec%0d_dq", i), 32'(dq), 32'(vt[i].ev));
            tick;
        end
        chk("write_mem", 32'(mem16[8'h10]), 32'h0000A534);

        // ---------------- starvation: 8 video grants per CPU access ----------------
        vid_req = 1'b1; vid_addr = 20'h00010;
        avs_read = 1'b1; avs_address = 20'h00055; avs_byteenable = 2'b11;
        acks = 0; comps = 0; vals = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_clk);
            if (vid_ack) acks++;
            if (vid_valid) vals++;
            if (!avs_waitrequest) begin
                comps++;
                chk($sformatf("starve_round%0d_acks", comps), 32'(acks), 32'd8);
                acks = 0;
            end
            if (comps == 3) break;
            tick;
        end
        chk("starve_comps", 32'(comps), 32'd3);
        chk("starve_valids", 32'(vals), 32'd24);
        tick;
        vid_req = 1'b0; avs_read = 1'b0;
        repeat (2) tick;

        // ---------------- reset during write ACCESS ----------------
        avs_write = 1'b1; avs_address = 20'h00020; avs_writedata = 16'h1357; avs_byteenable = 2'b11;
        @(negedge clk_clk);                       // IDLE, granted
        tick;
        @(negedge clk_clk);                       // ACCESS
        chk("rst_mid_we_before", 32'(we_n), 32'd0);
        reset_reset = 1'b1;
        tick;
        probe_en = 1'b1;
        @(negedge clk_clk);
        chk("rst_mid_we",   32'(we_n), 32'd1);
        chk("rst_mid_ce",   32'(ce_n), 32'd1);
        chk("rst_mid_dq",   32'(dq), 32'h0);
        chk("rst_mid_wait", 32'(avs_waitrequest), 32'd1);
        chk("rst_mid_addr", 32'(sram_addr), 32'h0);
        tick;
        reset_reset = 1'b0;
        probe_en = 1'b0;
        wcnt = 0; dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_clk);
            if (!we_n) wcnt++;
            if (!avs_waitrequest) dcnt++;
            tick;
            if (dcnt > 0) avs_write = 1'b0;
        end
        chk("rst_retry_we_cycles", 32'(wcnt), 32'd2);
        chk("rst_retry_done",      32'(dcnt), 32'd1);
        chk("rst_retry_mem",       32'(mem16[8'h20]), 32'h00001357);

        // ---------------- 32-bit, zero wait, zero turnaround ----------------
        avs_read_w = 1'b1; avs_address_w = 20'h00005; avs_byteenable_w = 4'hF;
        @(negedge clk_clk);
        chk("w32_rd_c0", 32'({avs_waitrequest_w, ce_n_w, oe_n_w, we_n_w}), 32'b1111);
        tick; @(negedge clk_clk);
        chk("w32_rd_c1", 32'({avs_waitrequest_w, ce_n_w, oe_n_w, we_n_w}), 32'b1001);
        tick; @(negedge clk_clk);
        chk("w32_rd_c2",   32'({avs_waitrequest_w, ce_n_w, oe_n_w, we_n_w}), 32'b0111);
        chk("w32_rd_data", avs_readdata_w, 32'hDEADBEEF);
        tick;
        avs_read_w = 1'b0; avs_write_w = 1'b1; avs_address_w = 20'h00006;
        avs_writedata_w = 32'h01234567; avs_byteenable_w = 4'b0011;
        @(negedge clk_clk);
        chk("w32_wr_c0", 32'({avs_waitrequest_w, ce_n_w, oe_n_w, we_n_w}), 32'b1111);
        tick; @(negedge clk_clk);
        chk("w32_wr_c1",  32'({avs_waitrequest_w, ce_n_w, oe_n_w, we_n_w}), 32'b1010);
        chk("w32_wr_ben", 32'(be_n_w), 32'b1100);
        tick; @(negedge clk_clk);
        chk("w32_wr_c2", 32'({avs_waitrequest_w, ce_n_w, oe_n_w, we_n_w}), 32'b0111);
        tick;
        avs_write_w = 1'b0; avs_read_w = 1'b1; avs_byteenable_w = 4'hF;
        @(negedge clk_clk);
        chk("w32_noturn_idle", 32'({avs_waitrequest_w, ce_n_w, oe_n_w, we_n_w}), 32'b1111);
        tick; @(negedge clk_clk);
        chk("w32_noturn_acc", 32'({avs_waitrequest_w, ce_n_w, oe_n_w, we_n_w}), 32'b1001);
        tick; @(negedge clk_clk);
        chk("w32_rb_done", 32'({avs_waitrequest_w, ce_n_w, oe_n_w, we_n_w}), 32'b0111);
        chk("w32_rb_data", avs_readdata_w, 32'hFFFF4567);
        tick;
        avs_read_w = 1'b0;
        repeat (2) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
